// File: rtl/audio_pdm_mixer_if.sv
// audio_pdm_mixer_if: sound-source inputs and PDM/clip outputs of the audio mixer
// master: drives sample_en, opl_snd, tandy_snd, speaker_in, atten, mute, clip_clear
// slave:  the mixer; drives aud_l, aud_r, clip
interface audio_pdm_mixer_if;
    logic        sample_en;
    logic [15:0] opl_snd;
    logic [7:0]  tandy_snd;
    logic        speaker_in;
    logic [2:0]  atten;
    logic        mute;
    logic        clip_clear;
    logic        aud_l;
    logic        aud_r;
    logic        clip;
    modport master (
        output sample_en, opl_snd, tandy_snd, speaker_in, atten, mute, clip_clear,
        input  aud_l, aud_r, clip
    );
    modport slave (
        input  sample_en, opl_snd, tandy_snd, speaker_in, atten, mute, clip_clear,
        output aud_l, aud_r, clip
    );
endinterface

// File: rtl/audio_pdm_mixer.sv
// audio_pdm_mixer: mixes OPL2, Tandy and PC-speaker into a clamped, attenuated 1-bit PDM stream
// clock_i : block clock
// reset_i : synchronous active-high reset
// bus     : slave side of audio_pdm_mixer_if (sources and controls in, aud_l/aud_r/clip out)
module audio_pdm_mixer #(
    parameter int unsigned OPL_SHIFT   = 2,
    parameter int unsigned TANDY_SHIFT = 5,
    parameter logic [15:0] SPK_LEVEL   = 16'h4000
) (
    input logic               clock_i,
    input logic               reset_i,
    audio_pdm_mixer_if.slave  bus
);
    logic               spk_meta_q;
    logic               spk_s_q;
    logic [15:0]        opl_q, opl_d;
    logic [7:0]         tand_q, tand_d;
    logic signed [19:0] sum;
    logic               sat_hi, sat_lo;
    logic [15:0]        mix_q, mix_d;
    logic               clip_q, clip_d;
    logic signed [15:0] mix_s, mix_shr;
    logic [15:0]        dac_q, dac_d;
    logic [16:0]        acc_q, acc_d;

    // The sum is one bit wider than the 19 bits the legal parameter range needs,
    // so the clamp comparison can never see a wrapped value.
    always_comb begin
        opl_d   = bus.sample_en ? bus.opl_snd : opl_q;
        tand_d  = bus.sample_en ? bus.tandy_snd : tand_q;
        sum     = ($signed({{4{opl_q[15]}}, opl_q}) <<< OPL_SHIFT)
                + $signed({12'd0, tand_q} << TANDY_SHIFT)
                + $signed({4'd0, spk_s_q ? SPK_LEVEL : 16'd0});
        sat_hi  = sum > 20'sd32767;
        sat_lo  = sum < -20'sd32768;
        mix_d   = sat_hi ? 16'h7FFF : sat_lo ? 16'h8000 : sum[15:0];
        // a saturation in the same cycle as a clear keeps the flag set
        clip_d  = sat_hi | sat_lo | (clip_q & ~bus.clip_clear);
        // shift kept in its own signed statement so it stays arithmetic
        mix_s   = $signed(mix_q);
        mix_shr = mix_s >>> bus.atten;
        dac_d   = bus.mute ? 16'd0 : mix_shr;
        // offset-binary input: carry density equals (dac ^ 8000h) / 65536
        acc_d   = {1'b0, acc_q[15:0]} + {1'b0, dac_q ^ 16'h8000};
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            spk_meta_q <= 1'b0;
            spk_s_q    <= 1'b0;
            opl_q      <= '0;
            tand_q     <= '0;
            mix_q      <= '0;
            clip_q     <= 1'b0;
            dac_q      <= '0;
            acc_q      <= '0;
        end else begin
            spk_meta_q <= bus.speaker_in;
            spk_s_q    <= spk_meta_q;
            opl_q      <= opl_d;
            tand_q     <= tand_d;
            mix_q      <= mix_d;
            clip_q     <= clip_d;
            dac_q      <= dac_d;
            acc_q      <= acc_d;
        end
    end

    assign bus.aud_l = acc_q[16];
    assign bus.aud_r = acc_q[16];
    assign bus.clip  = clip_q;
endmodule

// File: tb/tb_audio_pdm_mixer.sv
// tb_audio_pdm_mixer: table-driven, randomized and sequence checks of audio_pdm_mixer
module tb_audio_pdm_mixer;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    audio_pdm_mixer_if bus_if();

    audio_pdm_mixer dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus_if)
    );

    typedef struct {
        logic [15:0] opl;
        logic [7:0]  tand;
        logic        spk;
        logic [2:0]  atten;
        logic        mute;
        logic [15:0] mix;
        logic [15:0] dac;
        logic        clip;
    } vec_t;

    vec_t tbl[10];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic window(input int n, output int ones, output int diff);
        ones = 0;
        diff = 0;
        repeat (n) begin
            step();
            ones += int'(bus_if.aud_l);
            if (bus_if.aud_l !== bus_if.aud_r) diff++;
        end
    endtask

    // Reference: plain integer arithmetic from the mixing rules with default parameters.
    function automatic vec_t model(input vec_t v);
        int s, m, d, p;
        s = int'($signed(v.opl)) * 4 + int'(v.tand) * 32 + (v.spk ? 16384 : 0);
        m = s > 32767 ? 32767 : (s < -32768 ? -32768 : s);
        p = 1 << v.atten;
        d = m >= 0 ? m / p : -((-m + p - 1) / p);
        v.mix  = m[15:0];
        v.dac  = v.mute ? 16'h0000 : d[15:0];
        v.clip = (s > 32767) || (s < -32768);
        return v;
    endfunction

    // Over L cycles with constant u the ones count is floor or ceil of L*u/65536.
    task automatic run_vec(input string tag, input vec_t v, input int len);
        int ones, diff, u, lo, hi;
        bus_if.opl_snd    = v.opl;
        bus_if.tandy_snd  = v.tand;
        bus_if.speaker_in = v.spk;
        bus_if.atten      = v.atten;
        bus_if.mute       = v.mute;
        bus_if.sample_en  = 1'b1;
        step();
        bus_if.sample_en  = 1'b0;
        repeat (4) step();
        bus_if.clip_clear = 1'b1;
        step();
        bus_if.clip_clear = 1'b0;
        repeat (2) step();
        check({tag, "_mix"}, 32'(dut.mix_q), 32'(v.mix));
        check({tag, "_dac"}, 32'(dut.dac_q), 32'(v.dac));
        check({tag, "_clip"}, 32'(bus_if.clip), 32'(v.clip));
        window(len, ones, diff);
        u  = int'(v.dac ^ 16'h8000);
        lo = (len * u) >>> 16;
        hi = (len * u + 65535) >>> 16;
        check_range({tag, "_ones"}, ones, lo, hi);
        check({tag, "_lr"}, 32'(diff), 32'd0);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] pat;
        logic [7:0]  spk_pat;
        logic [1:0]  spk_seen;
        logic [15:0] dac3, dac4;
        int          ones, diff, n;
        vec_t        rv;

        tbl[0] = '{16'h1000, 8'h00, 1'b0, 3'd0, 1'b0, 16'h4000, 16'h4000, 1'b0};
        tbl[1] = '{16'h7FFF, 8'h00, 1'b1, 3'd0, 1'b0, 16'h7FFF, 16'h7FFF, 1'b1};
        tbl[2] = '{16'h8000, 8'h00, 1'b0, 3'd0, 1'b0, 16'h8000, 16'h8000, 1'b1};
        tbl[3] = '{16'h8000, 8'h00, 1'b0, 3'd0, 1'b1, 16'h8000, 16'h0000, 1'b1};
        tbl[4] = '{16'h1000, 8'h00, 1'b0, 3'd1, 1'b0, 16'h4000, 16'h2000, 1'b0};
        tbl[5] = '{16'h0000, 8'hFF, 1'b0, 3'd0, 1'b0, 16'h1FE0, 16'h1FE0, 1'b0};
        tbl[6] = '{16'hFFFF, 8'h00, 1'b0, 3'd7, 1'b0, 16'hFFFC, 16'hFFFF, 1'b0};
        tbl[7] = '{16'h1FF8, 8'h01, 1'b0, 3'd0, 1'b0, 16'h7FFF, 16'h7FFF, 1'b1};
        tbl[8] = '{16'hE000, 8'h00, 1'b0, 3'd0, 1'b0, 16'h8000, 16'h8000, 1'b0};
        tbl[9] = '{16'h0000, 8'h80, 1'b1, 3'd3, 1'b0, 16'h5000, 16'h0A00, 1'b0};

        rst               = 1'b1;
        bus_if.sample_en  = 1'b0;
        bus_if.opl_snd    = '0;
        bus_if.tandy_snd  = '0;
        bus_if.speaker_in = 1'b0;
        bus_if.atten      = '0;
        bus_if.mute       = 1'b0;
        bus_if.clip_clear = 1'b0;

        repeat (4) step();
        check("reset_aud", 32'(bus_if.aud_l), 32'd0);
        check("reset_clip", 32'(bus_if.clip), 32'd0);
        check("reset_acc", 32'(dut.acc_q), 32'd0);
        rst  = 1'b0;
        diff = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            pat[i] = bus_if.aud_l;
            if (bus_if.aud_l !== bus_if.aud_r || bus_if.clip !== 1'b0) diff++;
        end
        check("idle_pattern", 32'(pat), 32'h0000AAAA);
        check("idle_lr_clip", 32'(diff), 32'd0);

        bus_if.opl_snd   = 16'h0800;
        bus_if.sample_en = 1'b1;
        step();
        bus_if.opl_snd   = 16'h1000;
        step();
        bus_if.sample_en = 1'b0;
        check("last_wins_opl", 32'(dut.opl_q), 32'h1000);
        check("lat_mix_n", 32'(dut.mix_q), 32'h2000);
        step();
        check("lat_mix_n1", 32'(dut.mix_q), 32'h4000);
        check("lat_dac_n1", 32'(dut.dac_q), 32'h2000);
        step();
        check("lat_dac_n2", 32'(dut.dac_q), 32'h4000);

        for (int i = 0; i < 10; i++)
            run_vec($sformatf("vec%0d", i), tbl[i], 4096);

        for (int i = 0; i < 8; i++) begin
            rv.opl   = 16'($urandom);
            rv.tand  = 8'($urandom);
            rv.spk   = 1'($urandom);
            rv.atten = 3'($urandom_range(0, 7));
            rv.mute  = ($urandom_range(0, 7) == 0);
            rv = model(rv);
            run_vec($sformatf("rnd%0d", i), rv, 2048);
        end

        bus_if.opl_snd    = 16'h7FFF;
        bus_if.tandy_snd  = 8'h00;
        bus_if.speaker_in = 1'b1;
        bus_if.atten      = 3'd0;
        bus_if.mute       = 1'b0;
        bus_if.sample_en  = 1'b1;
        step();
        bus_if.sample_en  = 1'b0;
        repeat (6) step();
        n = 0;
        while (dut.acc_q[15:0] == 16'h0 && n < 8) begin
            step();
            n++;
        end
        check("mid_acc_nonzero", 32'(dut.acc_q[15:0] != 16'h0), 32'd1);
        check("mid_clip_before", 32'(bus_if.clip), 32'd1);
        rst = 1'b1;
        step();
        check("mid_reset_acc", 32'(dut.acc_q), 32'd0);
        check("mid_reset_clip", 32'(bus_if.clip), 32'd0);
        check("mid_reset_aud", 32'(bus_if.aud_l), 32'd0);
        check("mid_reset_mix", 32'(dut.mix_q), 32'd0);
        check("mid_reset_opl", 32'(dut.opl_q), 32'd0);

        bus_if.opl_snd = 16'h0000;
        step();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            spk_pat[i] = bus_if.aud_l;
            if (i < 2) spk_seen[i] = dut.spk_s_q;
            if (i == 2) dac3 = dut.dac_q;
            if (i == 3) dac4 = dut.dac_q;
        end
        check("spk_sync", 32'(spk_seen), 32'h2);
        check("spk_dac_e3", 32'(dac3), 32'h0000);
        check("spk_dac_e4", 32'(dac4), 32'h4000);
        check("spk_aud_seq", 32'(spk_pat), 32'h000000EA);
        window(4096, ones, diff);
        check("spk_ones", 32'(ones), 32'd3072);
        bus_if.speaker_in = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
